// File: rtl/box_count_scheduler.sv
// ---------------------------------------------------------------------------
// box_count_scheduler
//
// Frame-level controller for a bank of NUM_BOX per-box point-count
// accumulators in the LiDAR car-detection path.
//
// Each frame:
//   1. Clear all accumulators.
//   2. Stream in classified points.
//   3. Wait one cycle for the accumulator register stage.
//   4. Threshold the counts.
//   5. Hand the per-box detection vector downstream over valid/ready.
//
// Optional build macro:
//   BOX_CNT_SAT_EN - when defined, a box whose count is already at all-ones
//                    gets no further clock enable, so its count saturates.
//                    When undefined, counts wrap modulo 2^CNT_W.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active low
//   frame_start  single-cycle pulse that starts a frame (honoured in IDLE only)
//   pt_valid     point present on pt_hit / pt_last
//   pt_ready     point accepted this cycle when pt_valid is also high
//   pt_hit       bit i = point lies inside box i
//   pt_last      accepted point is the last one of the frame
//   acc_rst      synchronous active-low clear to all accumulators
//   acc_ce       per-accumulator clock enable
//   acc_a        per-accumulator increment input
//   acc_cnt      accumulator outputs, box i at [i*CNT_W +: CNT_W]
//   det_valid    detection vector valid
//   det_ready    downstream consumes det_flags
//   det_flags    bit i = count of box i >= THRESH
//   busy         controller is not idle
// ---------------------------------------------------------------------------
module box_count_scheduler #(
  parameter int NUM_BOX = 8,
  parameter int CNT_W   = 4,
  parameter int THRESH  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_start,
  input  logic                     pt_valid,
  output logic                     pt_ready,
  input  logic [NUM_BOX-1:0]       pt_hit,
  input  logic                     pt_last,
  output logic                     acc_rst,
  output logic [NUM_BOX-1:0]       acc_ce,
  output logic [NUM_BOX-1:0]       acc_a,
  input  logic [NUM_BOX*CNT_W-1:0] acc_cnt,
  output logic                     det_valid,
  input  logic                     det_ready,
  output logic [NUM_BOX-1:0]       det_flags,
  output logic                     busy
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    DRAIN,
    REPORT
  } state_t;

  state_t state_reg, state_next;

  logic [NUM_BOX-1:0] det_flags_reg, det_flags_next;
  logic [NUM_BOX-1:0] hit_ok;      // pt_hit after optional saturation gating
  logic [NUM_BOX-1:0] over_thresh; // live threshold compare of acc_cnt

  // Per-box saturation gate and threshold compare.
  generate
    for (genvar gi = 0; gi < NUM_BOX; gi++) begin : g_box
`ifdef BOX_CNT_SAT_EN
      assign hit_ok[gi] = pt_hit[gi] &
                          (acc_cnt[gi*CNT_W +: CNT_W] != {CNT_W{1'b1}});
`else
      assign hit_ok[gi] = pt_hit[gi];
`endif
      assign over_thresh[gi] = (acc_cnt[gi*CNT_W +: CNT_W] >= CNT_W'(THRESH));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      det_flags_reg <= '0;
    end else begin
      state_reg     <= state_next;
      det_flags_reg <= det_flags_next;
    end
  end

  // Next-state and outputs.
  //
  // Outputs are qualified by rst so that, while reset is held, the
  // accumulators are cleared and no point is accepted, even before the
  // first clock edge has loaded IDLE.
  always_comb begin
    state_next     = state_reg;
    det_flags_next = det_flags_reg;
    pt_ready       = 1'b0;
    acc_rst        = 1'b1;
    acc_ce         = '0;
    acc_a          = '0;
    det_valid      = 1'b0;

    if (!rst) begin
      state_next = IDLE;
      acc_rst    = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (frame_start) state_next = CLEAR;
        end

        CLEAR: begin
          // Enable asserted alongside the clear so the clear lands on
          // accumulators that qualify clear with CE as well.
          acc_rst    = 1'b0;
          acc_ce     = '1;
          state_next = ACCUM;
        end

        ACCUM: begin
          pt_ready = 1'b1;
          if (pt_valid) begin
            acc_ce = hit_ok;
            acc_a  = hit_ok;
            if (pt_last) state_next = DRAIN;
          end
        end

        DRAIN: begin
          // The last point's increment has landed in the accumulators by
          // now. Capture the flags on the way into REPORT so they are
          // already stable in REPORT's first cycle.
          det_flags_next = over_thresh;
          state_next     = REPORT;
        end

        REPORT: begin
          det_valid = 1'b1;
          if (det_ready) state_next = IDLE;
        end

        default: state_next = IDLE;
      endcase
    end
  end

  assign det_flags = det_flags_reg;
  assign busy      = (state_reg != IDLE);

endmodule
